// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// One access is in flight at a time: an IDLE cycle selects the winner and an ISSUE cycle drives the RAM.
module ram_arbiter #(
  parameter int A          = 10,
  parameter int D          = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic         rw0,
  input  logic         rw1,
  input  logic [A-1:0] addr0,
  input  logic [A-1:0] addr1,
  input  logic [D-1:0] wdata0,
  input  logic [D-1:0] wdata1,
  output logic         ack0,
  output logic         ack1,
  output logic [D-1:0] rdata0,
  output logic [D-1:0] rdata1,
  output logic         rvalid0,
  output logic         rvalid1,
  output logic         ram_cs,
  output logic         ram_rw,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_data_in,
  input  logic [D-1:0] ram_data_out
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t state;
  logic   last_grant;
  logic   pick1;

  assign rdata0 = ram_data_out;
  assign rdata1 = ram_data_out;

  // last_grant doubles as the owner of the access currently in ISSUE
  always_comb begin
    pick1 = 1'b0;
    if (req1 && !req0)
      pick1 = 1'b1;
    else if (req0 && req1 && FIXED_PRIO == 0)
      pick1 = ~last_grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ram_cs      <= 1'b0;
      ram_rw      <= 1'b1;
      ram_addr    <= '0;
      ram_data_in <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          if (req0 || req1) begin
            state       <= ISSUE;
            ram_cs      <= 1'b1;
            ram_rw      <= pick1 ? rw1 : rw0;
            ram_addr    <= pick1 ? addr1 : addr0;
            ram_data_in <= pick1 ? wdata1 : wdata0;
            ack0        <= ~pick1;
            ack1        <= pick1;
            last_grant  <= pick1;
          end
        end
        ISSUE: begin
          state   <= IDLE;
          ram_cs  <= 1'b0;
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          rvalid0 <= ram_rw & ~last_grant;
          rvalid1 <= ram_rw & last_grant;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
